// File: rtl/sram_access_sequencer.sv
// sram_access_sequencer
// Owns the pins of a 16x4 SRAM built from two cascaded 8x4 banks.
// Turns single read/write requests into CS/WE strobe sequences with
// setup and hold cycles, returns read data with a one-cycle response
// pulse, and offers a fill mode that writes one pattern to every word.
module sram_access_sequencer #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4,
  parameter int READ_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqData,
  input  logic              fillStart,
  input  logic [DATA_W-1:0] fillPattern,
  output logic              fillDone,
  output logic              busy,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspData,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataInp,
  output logic              memChipSelect,
  output logic              memWriteEnable,
  input  logic [DATA_W-1:0] memDataOutp
);

  // Wait counter only needs to hold READ_WAIT-1 down to 0.
  localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RD_ACCESS,
    RD_RESP
  } state_t;

  state_t            state;
  logic              fill_mode;
  logic [ADDR_W-1:0] fill_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  // Requests are taken only from IDLE, and a simultaneous fillStart wins.
  // Ready is also withheld while reset is asserted.
  assign reqReady = rst_n & (state == IDLE) & ~fillStart;

  // Sequencer state, pin strobes and response/fill status, all registered.
  // Address and write data change only on the edge entering WR_SETUP or
  // RD_ACCESS, when WE is low, so WE never overlaps an address change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      fill_mode      <= 1'b0;
      fill_cnt       <= '0;
      wait_cnt       <= '0;
      fillDone       <= 1'b0;
      busy           <= 1'b0;
      rspValid       <= 1'b0;
      rspData        <= '0;
      memAddr        <= '0;
      memDataInp     <= '0;
      memChipSelect  <= 1'b0;
      memWriteEnable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          memChipSelect  <= 1'b0;
          memWriteEnable <= 1'b0;
          rspValid       <= 1'b0;
          fillDone       <= 1'b0;
          if (fillStart) begin
            // Pattern stays on memDataInp for the whole fill.
            fill_mode     <= 1'b1;
            fill_cnt      <= '0;
            memAddr       <= '0;
            memDataInp    <= fillPattern;
            memChipSelect <= 1'b1;
            busy          <= 1'b1;
            state         <= WR_SETUP;
          end else if (reqValid) begin
            memAddr       <= reqAddr;
            memChipSelect <= 1'b1;
            busy          <= 1'b1;
            if (reqWrite) begin
              memDataInp <= reqData;
              state      <= WR_SETUP;
            end else begin
              wait_cnt <= WAIT_W'(READ_WAIT - 1);
              state    <= RD_ACCESS;
            end
          end
        end

        WR_SETUP: begin
          memWriteEnable <= 1'b1;
          state          <= WR_STROBE;
        end

        WR_STROBE: begin
          memWriteEnable <= 1'b0;
          state          <= WR_HOLD;
        end

        WR_HOLD: begin
          if (fill_mode && (fill_cnt != {ADDR_W{1'b1}})) begin
            // Next fill word: CS stays asserted, address moves with WE low.
            fill_cnt <= fill_cnt + 1'b1;
            memAddr  <= fill_cnt + 1'b1;
            state    <= WR_SETUP;
          end else begin
            if (fill_mode) begin
              fill_mode <= 1'b0;
              fill_cnt  <= '0;
              fillDone  <= 1'b1;
            end
            memChipSelect <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end

        RD_ACCESS: begin
          if (wait_cnt == '0) begin
            rspData       <= memDataOutp;
            rspValid      <= 1'b1;
            memChipSelect <= 1'b0;
            state         <= RD_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        RD_RESP: begin
          rspValid <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          memChipSelect  <= 1'b0;
          memWriteEnable <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
